// File: rtl/itlb_miss_ctrl.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : itlb_miss_ctrl
//  Purpose  : ITLB miss sequencer. Holds one entry per L2 TLB tag and merges
//             repeated misses to the same {ASID,VPN}. Issues one tagged L2
//             TLB request per unique miss, and turns each L2 TLB response into
//             a single one-cycle fill toward the ITLB 4KB/4MB arrays.
//  Ports    : CLK/RST                      clock, async active-high reset
//             miss_valid/vpn/asid/ready    ITLB lookup miss handshake
//             l2_req_*                     registered tagged request to L2 TLB
//             l2_resp_*                    tagged walk result from L2 TLB
//             fill_*                       registered fill pulse to the ITLB
//             flush_valid                  sfence.vma, kills pending misses
//             busy                         any entry not FREE
//  Revision : 1.0 - initial release
// ============================================================================
module itlb_miss_ctrl #(
  parameter int TAG_COUNT  = 4,
  parameter int TAG_WIDTH  = 2,
  parameter int VPN_WIDTH  = 20,
  parameter int ASID_WIDTH = 9
) (
  input  logic                  CLK,
  input  logic                  RST,
  // miss from ITLB lookup
  input  logic                  miss_valid,
  input  logic [VPN_WIDTH-1:0]  miss_vpn,
  input  logic [ASID_WIDTH-1:0] miss_asid,
  output logic                  miss_ready,
  // request to L2 TLB
  output logic                  l2_req_valid,
  output logic [TAG_WIDTH-1:0]  l2_req_tag,
  output logic [VPN_WIDTH-1:0]  l2_req_vpn,
  output logic [ASID_WIDTH-1:0] l2_req_asid,
  input  logic                  l2_req_ready,
  // response from L2 TLB
  input  logic                  l2_resp_valid,
  input  logic [TAG_WIDTH-1:0]  l2_resp_tag,
  input  logic [31:0]           l2_resp_pte,
  input  logic                  l2_resp_is_4mb,
  input  logic                  l2_resp_fault,
  // fill to ITLB
  output logic                  fill_valid,
  output logic [VPN_WIDTH-1:0]  fill_vpn,
  output logic [ASID_WIDTH-1:0] fill_asid,
  output logic [31:0]           fill_pte,
  output logic                  fill_is_4mb,
  output logic                  fill_fault,
  // control / status
  input  logic                  flush_valid,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_FREE      = 2'd0,
    ST_WAIT_REQ  = 2'd1,
    ST_WAIT_RESP = 2'd2,
    ST_FLUSHED   = 2'd3
  } entry_state_t;

  // per-entry storage
  entry_state_t          r_state     [TAG_COUNT];
  entry_state_t          w_state_nxt [TAG_COUNT];
  logic [VPN_WIDTH-1:0]  r_vpn       [TAG_COUNT];
  logic [ASID_WIDTH-1:0] r_asid      [TAG_COUNT];
  // entry currently sitting in the request register (not reselectable)
  logic [TAG_COUNT-1:0]  r_issuing;
  logic [TAG_COUNT-1:0]  w_issuing_nxt;

  // request register
  logic                  r_req_valid;
  logic [TAG_WIDTH-1:0]  r_req_tag;
  logic [VPN_WIDTH-1:0]  r_req_vpn;
  logic [ASID_WIDTH-1:0] r_req_asid;

  // fill register
  logic                  r_fill_valid;
  logic [VPN_WIDTH-1:0]  r_fill_vpn;
  logic [ASID_WIDTH-1:0] r_fill_asid;
  logic [31:0]           r_fill_pte;
  logic                  r_fill_is_4mb;
  logic                  r_fill_fault;

  logic [TAG_COUNT-1:0]  w_match;
  logic [TAG_COUNT-1:0]  w_free;
  logic [TAG_COUNT-1:0]  w_busy_vec;
  logic                  w_any_match;
  logic                  w_any_free;
  logic [TAG_WIDTH-1:0]  w_alloc_idx;
  logic                  w_accept;
  logic                  w_alloc;
  logic                  w_hs;
  logic                  w_can_load;
  logic [TAG_COUNT-1:0]  w_load_cand;
  logic                  w_load_found;
  logic [TAG_WIDTH-1:0]  w_load_idx;
  logic                  w_load;
  logic                  w_load_bypass;
  logic [VPN_WIDTH-1:0]  w_load_vpn;
  logic [ASID_WIDTH-1:0] w_load_asid;
  logic                  w_fill;

  // --------------------------------------------------------------------------
  // Per-entry match / free decode
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < TAG_COUNT; gi++) begin : g_entry
    assign w_match[gi] = ((r_state[gi] == ST_WAIT_REQ) || (r_state[gi] == ST_WAIT_RESP)) &&
                         (r_vpn[gi] == miss_vpn) && (r_asid[gi] == miss_asid);
    assign w_free[gi]     = (r_state[gi] == ST_FREE);
    assign w_busy_vec[gi] = (r_state[gi] != ST_FREE);
  end

  assign w_any_match = |w_match;
  assign miss_ready  = !flush_valid && (w_any_match || w_any_free);
  assign w_accept    = miss_valid && miss_ready;
  assign w_alloc     = w_accept && !w_any_match;
  assign w_hs        = r_req_valid && l2_req_ready;
  assign w_can_load  = !r_req_valid || w_hs;

  // lowest-index FREE entry; scanning downward lets the lowest index win
  always_comb begin
    w_any_free  = 1'b0;
    w_alloc_idx = '0;
    for (int i = TAG_COUNT - 1; i >= 0; i--) begin
      if (w_free[i]) begin
        w_any_free  = 1'b1;
        w_alloc_idx = TAG_WIDTH'(i);
      end
    end
  end

  // Request candidates: waiting entries not already in the request register,
  // plus the entry being allocated this cycle so the first request appears
  // the cycle after the miss is accepted.
  always_comb begin
    w_load_found = 1'b0;
    w_load_idx   = '0;
    for (int i = TAG_COUNT - 1; i >= 0; i--) begin
      w_load_cand[i] = ((r_state[i] == ST_WAIT_REQ) && !r_issuing[i]) ||
                       (w_alloc && (w_alloc_idx == TAG_WIDTH'(i)));
      if (w_load_cand[i]) begin
        w_load_found = 1'b1;
        w_load_idx   = TAG_WIDTH'(i);
      end
    end
  end

  assign w_load        = w_can_load && w_load_found && !flush_valid;
  assign w_load_bypass = w_alloc && (w_load_idx == w_alloc_idx);
  assign w_load_vpn    = w_load_bypass ? miss_vpn  : r_vpn[w_load_idx];
  assign w_load_asid   = w_load_bypass ? miss_asid : r_asid[w_load_idx];

  // Fill only for a live WAIT_RESP entry; a flush in the same cycle kills it.
  assign w_fill = l2_resp_valid && (r_state[l2_resp_tag] == ST_WAIT_RESP) && !flush_valid;

  // --------------------------------------------------------------------------
  // Entry FSM next-state
  // --------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < TAG_COUNT; i++) begin
      w_state_nxt[i] = r_state[i];
      unique case (r_state[i])
        ST_FREE: begin
          if (w_alloc && (w_alloc_idx == TAG_WIDTH'(i))) w_state_nxt[i] = ST_WAIT_REQ;
        end
        ST_WAIT_REQ: begin
          // a handshake coinciding with flush means the tag is already in flight
          if (w_hs && (r_req_tag == TAG_WIDTH'(i)))
            w_state_nxt[i] = flush_valid ? ST_FLUSHED : ST_WAIT_RESP;
          else if (flush_valid)
            w_state_nxt[i] = ST_FREE;
        end
        ST_WAIT_RESP: begin
          if (l2_resp_valid && (l2_resp_tag == TAG_WIDTH'(i))) w_state_nxt[i] = ST_FREE;
          else if (flush_valid)                                 w_state_nxt[i] = ST_FLUSHED;
        end
        ST_FLUSHED: begin
          if (l2_resp_valid && (l2_resp_tag == TAG_WIDTH'(i))) w_state_nxt[i] = ST_FREE;
        end
        default: w_state_nxt[i] = ST_FREE;
      endcase
    end
  end

  always_comb begin
    w_issuing_nxt = r_issuing;
    if (w_hs) w_issuing_nxt[r_req_tag] = 1'b0;
    if (w_load) w_issuing_nxt[w_load_idx] = 1'b1;
    if (flush_valid) w_issuing_nxt = '0;
  end

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < TAG_COUNT; i++) begin
        r_state[i] <= ST_FREE;
        r_vpn[i]   <= '0;
        r_asid[i]  <= '0;
      end
      r_issuing <= '0;
    end else begin
      for (int i = 0; i < TAG_COUNT; i++) r_state[i] <= w_state_nxt[i];
      r_issuing <= w_issuing_nxt;
      if (w_alloc) begin
        r_vpn[w_alloc_idx]  <= miss_vpn;
        r_asid[w_alloc_idx] <= miss_asid;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_req_valid <= 1'b0;
      r_req_tag   <= '0;
      r_req_vpn   <= '0;
      r_req_asid  <= '0;
    end else if (flush_valid) begin
      r_req_valid <= 1'b0;
    end else if (w_can_load) begin
      r_req_valid <= w_load_found;
      if (w_load_found) begin
        r_req_tag  <= w_load_idx;
        r_req_vpn  <= w_load_vpn;
        r_req_asid <= w_load_asid;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_fill_valid  <= 1'b0;
      r_fill_vpn    <= '0;
      r_fill_asid   <= '0;
      r_fill_pte    <= '0;
      r_fill_is_4mb <= 1'b0;
      r_fill_fault  <= 1'b0;
    end else begin
      r_fill_valid <= w_fill;
      if (w_fill) begin
        r_fill_vpn    <= r_vpn[l2_resp_tag];
        r_fill_asid   <= r_asid[l2_resp_tag];
        r_fill_pte    <= l2_resp_pte;
        r_fill_is_4mb <= l2_resp_is_4mb;
        r_fill_fault  <= l2_resp_fault;
      end
    end
  end

  assign l2_req_valid = r_req_valid;
  assign l2_req_tag   = r_req_tag;
  assign l2_req_vpn   = r_req_vpn;
  assign l2_req_asid  = r_req_asid;
  assign fill_valid   = r_fill_valid;
  assign fill_vpn     = r_fill_vpn;
  assign fill_asid    = r_fill_asid;
  assign fill_pte     = r_fill_pte;
  assign fill_is_4mb  = r_fill_is_4mb;
  assign fill_fault   = r_fill_fault;
  assign busy         = |w_busy_vec;

  // A response may only target an entry that actually has a request in flight.
  a_resp_tag_live: assert property (@(posedge CLK) disable iff (RST)
    l2_resp_valid |-> ((r_state[l2_resp_tag] == ST_WAIT_RESP) ||
                       (r_state[l2_resp_tag] == ST_FLUSHED)));

endmodule
`default_nettype wire

// File: tb/tb_itlb_miss_ctrl.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : tb_itlb_miss_ctrl
//  Purpose  : Self-checking bench for itlb_miss_ctrl: a vector table for the
//             basic request/fill flow and tag exhaustion, then hand-written
//             sequences for request stall, out-of-order responses, flush and
//             faulting superpage fills with a same-cycle merged miss.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_itlb_miss_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        miss_valid;
  logic [19:0] miss_vpn;
  logic [8:0]  miss_asid;
  logic        miss_ready;
  logic        l2_req_valid;
  logic [1:0]  l2_req_tag;
  logic [19:0] l2_req_vpn;
  logic [8:0]  l2_req_asid;
  logic        l2_req_ready;
  logic        l2_resp_valid;
  logic [1:0]  l2_resp_tag;
  logic [31:0] l2_resp_pte;
  logic        l2_resp_is_4mb;
  logic        l2_resp_fault;
  logic        fill_valid;
  logic [19:0] fill_vpn;
  logic [8:0]  fill_asid;
  logic [31:0] fill_pte;
  logic        fill_is_4mb;
  logic        fill_fault;
  logic        flush_valid;
  logic        busy;

  int total = 0;
  int bad   = 0;

  itlb_miss_ctrl #(
    .TAG_COUNT(4), .TAG_WIDTH(2), .VPN_WIDTH(20), .ASID_WIDTH(9)
  ) dut (
    .CLK(CLK), .RST(RST),
    .miss_valid(miss_valid), .miss_vpn(miss_vpn), .miss_asid(miss_asid),
    .miss_ready(miss_ready),
    .l2_req_valid(l2_req_valid), .l2_req_tag(l2_req_tag), .l2_req_vpn(l2_req_vpn),
    .l2_req_asid(l2_req_asid), .l2_req_ready(l2_req_ready),
    .l2_resp_valid(l2_resp_valid), .l2_resp_tag(l2_resp_tag), .l2_resp_pte(l2_resp_pte),
    .l2_resp_is_4mb(l2_resp_is_4mb), .l2_resp_fault(l2_resp_fault),
    .fill_valid(fill_valid), .fill_vpn(fill_vpn), .fill_asid(fill_asid),
    .fill_pte(fill_pte), .fill_is_4mb(fill_is_4mb), .fill_fault(fill_fault),
    .flush_valid(flush_valid), .busy(busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        mv;
    logic [19:0] vpn;
    logic [8:0]  asid;
    logic        rr;
    logic        rv;
    logic [1:0]  rtag;
    logic [31:0] pte;
    logic        fl;
    logic        e_mr;    // miss_ready before the edge
    logic        e_rqv;   // l2_req_valid after the edge
    logic [1:0]  e_rqt;   // l2_req_tag after the edge (checked when valid)
    logic        e_fv;    // fill_valid after the edge
    logic [31:0] e_fpte;  // fill_pte after the edge (checked when fill)
    logic        e_busy;  // busy after the edge
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic mv, input logic [19:0] vpn, input logic [8:0] asid,
                       input logic rr, input logic rv, input logic [1:0] rtag,
                       input logic [31:0] pte, input logic r4, input logic rf,
                       input logic fl);
    miss_valid     = mv;
    miss_vpn       = vpn;
    miss_asid      = asid;
    l2_req_ready   = rr;
    l2_resp_valid  = rv;
    l2_resp_tag    = rtag;
    l2_resp_pte    = pte;
    l2_resp_is_4mb = r4;
    l2_resp_fault  = rf;
    flush_valid    = fl;
  endtask

  task automatic idle(input logic rr);
    drive(1'b0, 20'h0, 9'h0, rr, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // advance one clock; outputs sampled 1ns after the edge
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    idle(1'b0);

    // vector table: scenario 1 (single miss) then scenario 2 (tag exhaustion)
    //          mv    vpn       asid  rr    rv    tag   pte            fl    mr    rqv   rqt   fv    fpte           busy
    vecs[0]  = '{1'b1, 20'h12345, 9'd3, 1'b1, 1'b0, 2'd0, 32'h0,         1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0,         1'b1};
    vecs[1]  = '{1'b0, 20'h00000, 9'd0, 1'b1, 1'b0, 2'd0, 32'h0,         1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0,         1'b1};
    vecs[2]  = '{1'b0, 20'h00000, 9'd0, 1'b1, 1'b1, 2'd0, 32'h0ABCDE01,  1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h0ABCDE01,  1'b0};
    vecs[3]  = '{1'b0, 20'h00000, 9'd0, 1'b1, 1'b0, 2'd0, 32'h0,         1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0,         1'b0};
    vecs[4]  = '{1'b1, 20'h00100, 9'd1, 1'b0, 1'b0, 2'd0, 32'h0,         1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0,         1'b1};
    vecs[5]  = '{1'b1, 20'h00200, 9'd1, 1'b0, 1'b0, 2'd0, 32'h0,         1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0,         1'b1};
    vecs[6]  = '{1'b1, 20'h00300, 9'd1, 1'b0, 1'b0, 2'd0, 32'h0,         1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0,         1'b1};
    vecs[7]  = '{1'b1, 20'h00400, 9'd1, 1'b0, 1'b0, 2'd0, 32'h0,         1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0,         1'b1};
    vecs[8]  = '{1'b1, 20'h00500, 9'd1, 1'b0, 1'b0, 2'd0, 32'h0,         1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0,         1'b1};
    vecs[9]  = '{1'b1, 20'h00200, 9'd1, 1'b0, 1'b0, 2'd0, 32'h0,         1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0,         1'b1};
    vecs[10] = '{1'b1, 20'h00200, 9'd2, 1'b0, 1'b0, 2'd0, 32'h0,         1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0,         1'b1};

    // reset
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_req_valid", 32'(l2_req_valid), 32'd0);
    chk("rst_fill_valid", 32'(fill_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_vpn", 32'(l2_req_vpn), 32'd0);
    chk("rst_fill_pte", fill_pte, 32'd0);
    RST = 1'b0;

    for (int k = 0; k < 11; k++) begin
      drive(vecs[k].mv, vecs[k].vpn, vecs[k].asid, vecs[k].rr, vecs[k].rv, vecs[k].rtag,
            vecs[k].pte, 1'b0, 1'b0, vecs[k].fl);
      #1;
      chk($sformatf("v%0d_miss_ready", k), 32'(miss_ready), 32'(vecs[k].e_mr));
      cyc();
      chk($sformatf("v%0d_req_valid", k), 32'(l2_req_valid), 32'(vecs[k].e_rqv));
      if (vecs[k].e_rqv) chk($sformatf("v%0d_req_tag", k), 32'(l2_req_tag), 32'(vecs[k].e_rqt));
      chk($sformatf("v%0d_fill_valid", k), 32'(fill_valid), 32'(vecs[k].e_fv));
      if (vecs[k].e_fv) chk($sformatf("v%0d_fill_pte", k), fill_pte, vecs[k].e_fpte);
      chk($sformatf("v%0d_busy", k), 32'(busy), 32'(vecs[k].e_busy));
    end

    // scenario 3: request payload held stable while ready is low
    idle(1'b0);
    for (int t = 0; t < 5; t++) begin
      cyc();
      chk("stall_valid", 32'(l2_req_valid), 32'd1);
      chk("stall_tag", 32'(l2_req_tag), 32'd0);
      chk("stall_vpn", 32'(l2_req_vpn), 32'h00100);
      chk("stall_asid", 32'(l2_req_asid), 32'd1);
    end
    // drain all four requests in tag order
    idle(1'b1);
    for (int t = 0; t < 4; t++) begin
      cyc();
      if (t < 3) begin
        chk("drain_valid", 32'(l2_req_valid), 32'd1);
        chk("drain_tag", 32'(l2_req_tag), 32'(t + 1));
        chk("drain_vpn", 32'(l2_req_vpn), 32'h00100 * 32'(t + 2));
      end else begin
        chk("drain_done", 32'(l2_req_valid), 32'd0);
      end
    end
    // out-of-order responses: tag2 then tag0
    drive(1'b0, 20'h0, 9'h0, 1'b1, 1'b1, 2'd2, 32'h00000022, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("ooo1_fill_valid", 32'(fill_valid), 32'd1);
    chk("ooo1_fill_vpn", 32'(fill_vpn), 32'h00300);
    chk("ooo1_fill_pte", fill_pte, 32'h00000022);
    drive(1'b0, 20'h0, 9'h0, 1'b1, 1'b1, 2'd0, 32'h00000011, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("ooo2_fill_valid", 32'(fill_valid), 32'd1);
    chk("ooo2_fill_vpn", 32'(fill_vpn), 32'h00100);
    chk("ooo2_fill_asid", 32'(fill_asid), 32'd1);
    chk("ooo2_fill_pte", fill_pte, 32'h00000011);
    idle(1'b1);
    cyc();
    chk("ooo_fill_pulse", 32'(fill_valid), 32'd0);
    chk("ooo_busy", 32'(busy), 32'd1);
    // retire the remaining tags 1 and 3
    drive(1'b0, 20'h0, 9'h0, 1'b1, 1'b1, 2'd1, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 20'h0, 9'h0, 1'b1, 1'b1, 2'd3, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc();
    idle(1'b0);
    cyc();
    chk("cleanup_busy", 32'(busy), 32'd0);

    // scenario 4: flush with tag0 WAIT_RESP and tag1 WAIT_REQ
    drive(1'b1, 20'h0AAAA, 9'd5, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("fl_a_tag", 32'(l2_req_tag), 32'd0);
    drive(1'b1, 20'h0BBBB, 9'd5, 1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("fl_b_valid", 32'(l2_req_valid), 32'd1);
    chk("fl_b_tag", 32'(l2_req_tag), 32'd1);
    chk("fl_b_vpn", 32'(l2_req_vpn), 32'h0BBBB);
    drive(1'b1, 20'h0EEEE, 9'd5, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("fl_miss_ready", 32'(miss_ready), 32'd0);
    cyc();
    chk("fl_req_dropped", 32'(l2_req_valid), 32'd0);
    chk("fl_busy", 32'(busy), 32'd1);
    drive(1'b0, 20'h0, 9'h0, 1'b0, 1'b1, 2'd0, 32'h00000099, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("fl_resp_no_fill", 32'(fill_valid), 32'd0);
    chk("fl_resp_busy", 32'(busy), 32'd0);
    drive(1'b1, 20'h0CCCC, 9'd6, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("fl_realloc_valid", 32'(l2_req_valid), 32'd1);
    chk("fl_realloc_tag", 32'(l2_req_tag), 32'd0);
    chk("fl_realloc_vpn", 32'(l2_req_vpn), 32'h0CCCC);

    // scenario 5: faulting superpage response with same-cycle merged miss
    drive(1'b1, 20'h0DDDD, 9'd7, 1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("f5_req_tag", 32'(l2_req_tag), 32'd1);
    chk("f5_req_asid", 32'(l2_req_asid), 32'd7);
    idle(1'b1);
    cyc();
    chk("f5_req_idle", 32'(l2_req_valid), 32'd0);
    drive(1'b1, 20'h0DDDD, 9'd7, 1'b1, 1'b1, 2'd1, 32'h12345678, 1'b1, 1'b1, 1'b0);
    #1;
    chk("f5_merge_ready", 32'(miss_ready), 32'd1);
    cyc();
    chk("f5_fill_valid", 32'(fill_valid), 32'd1);
    chk("f5_fill_vpn", 32'(fill_vpn), 32'h0DDDD);
    chk("f5_fill_asid", 32'(fill_asid), 32'd7);
    chk("f5_fill_pte", fill_pte, 32'h12345678);
    chk("f5_fill_4mb", 32'(fill_is_4mb), 32'd1);
    chk("f5_fill_fault", 32'(fill_fault), 32'd1);
    chk("f5_no_new_req", 32'(l2_req_valid), 32'd0);
    idle(1'b1);
    cyc();
    chk("f5_no_new_req2", 32'(l2_req_valid), 32'd0);
    chk("f5_fill_pulse", 32'(fill_valid), 32'd0);
    chk("f5_busy", 32'(busy), 32'd1);
    drive(1'b0, 20'h0, 9'h0, 1'b1, 1'b1, 2'd0, 32'h00000077, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("f5_last_fill_vpn", 32'(fill_vpn), 32'h0CCCC);
    chk("f5_last_fault", 32'(fill_fault), 32'd0);
    chk("f5_final_busy", 32'(busy), 32'd0);
    idle(1'b0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
